my_top_level: RTL and testbench

Registered 8-bit adder used as the top-level datapath block of the adder test design. Each cycle it samples two unsigned operands on the rising clock edge and produces their modulo-2^WIDTH sum after a fixed pipeline latency. An optional compile-time mode replaces wrap-around with saturating addition. It has no handshake: a new operand pair is accepted every cycle, and the output is a pure delayed function of the inputs.

---
 rtl/my_top_level.sv | 44 ++++
 tb/tb_my_top_level.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/my_top_level.sv
// Registered WIDTH-bit adder with a LATENCY-deep output delay line.
// Define MY_TOP_LEVEL_SAT_EN to saturate on carry-out instead of wrapping.
module my_top_level #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] pipe [LATENCY];

    assign sum = {1'b0, io_A} + {1'b0, io_B};

`ifdef MY_TOP_LEVEL_SAT_EN
    assign result = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    // Carry is dropped in wrap mode; kept as a named sink so the unused bit is intentional.
    logic unused_carry;
    assign unused_carry = sum[WIDTH];
    assign result       = sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= result;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign io_X = pipe[LATENCY-1];

endmodule

// File: tb/tb_my_top_level.sv
// Bench for my_top_level: WIDTH 8 and 16 at LATENCY 1..4, checked against a
// history-based arithmetic model plus table vectors and hand-written sequences.
module tb_my_top_level;

`ifdef MY_TOP_LEVEL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  x8  [4];
    logic [15:0] x16 [4];

    int checks   = 0;
    int failures = 0;

    bit          hr[$];
    logic [15:0] ha[$];
    logic [15:0] hb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        my_top_level #(.WIDTH(8), .LATENCY(g + 1)) u_dut8 (
            .clk   (clk),
            .reset (reset),
            .io_A  (a[7:0]),
            .io_B  (b[7:0]),
            .io_X  (x8[g])
        );
        my_top_level #(.WIDTH(16), .LATENCY(g + 1)) u_dut16 (
            .clk   (clk),
            .reset (reset),
            .io_A  (a),
            .io_B  (b),
            .io_X  (x16[g])
        );
    end

    // Expected output after the newest recorded edge for a given width and latency.
    function automatic longint model(input int w, input int lat);
        int     n;
        int     src;
        longint mask;
        longint s;
        n    = hr.size() - 1;
        src  = n - lat + 1;
        mask = (longint'(1) << w) - 1;
        for (int j = (src < 0) ? 0 : src; j <= n; j++) begin
            if (hr[j]) return 0;
        end
        s = (longint'(ha[src]) & mask) + (longint'(hb[src]) & mask);
        if (SAT && s > mask) return mask;
        return s & mask;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input longint exp);
        checks++;
        if (act !== exp[15:0]) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input logic [15:0] va, input logic [15:0] vb);
        reset = r;
        a     = va;
        b     = vb;
        @(posedge clk);
        hr.push_back(r);
        ha.push_back(va);
        hb.push_back(vb);
        #1;
        for (int l = 0; l < 4; l++) begin
            check($sformatf("model_w8_lat%0d", l + 1), {8'd0, x8[l]}, model(8, l + 1));
            check($sformatf("model_w16_lat%0d", l + 1), x16[l], model(16, l + 1));
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        longint      w8;
        longint      s8;
        longint      w16;
        longint      s16;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] corner[6];
        longint      e8;
        longint      e16;

        vecs[0] = '{16'd37,    16'd90,   127, 127, 127,   127};
        vecs[1] = '{16'd255,   16'd1,    0,   255, 256,   256};
        vecs[2] = '{16'd128,   16'd128,  0,   255, 256,   256};
        vecs[3] = '{16'd127,   16'd128,  255, 255, 255,   255};
        vecs[4] = '{16'd200,   16'd100,  44,  255, 300,   300};
        vecs[5] = '{16'd199,   16'd199,  142, 255, 398,   398};
        vecs[6] = '{16'd65535, 16'd1,    0,   255, 0,     65535};
        vecs[7] = '{16'd0,     16'd0,    0,   0,   0,     0};
        vecs[8] = '{16'd65000, 16'd1000, 208, 255, 464,   65535};
        corner  = '{16'd0, 16'd1, 16'd127, 16'd128, 16'd255, 16'd65535};

        // Reset hold with live operands: every output must stay 0.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 16'd37, 16'd90);
            for (int l = 0; l < 4; l++) begin
                check("reset_hold_w8", {8'd0, x8[l]}, 0);
                check("reset_hold_w16", x16[l], 0);
            end
        end

        // Release: 127 appears exactly LATENCY edges after release.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 16'd37, 16'd90);
            for (int l = 0; l < 4; l++) begin
                check($sformatf("release_w8_lat%0d", l + 1), {8'd0, x8[l]}, (k >= l) ? 127 : 0);
                check($sformatf("release_w16_lat%0d", l + 1), x16[l], (k >= l) ? 127 : 0);
            end
        end

        // Table vectors: hold each pair long enough to fill the deepest pipeline.
        foreach (vecs[i]) begin
            repeat (4) step(1'b0, vecs[i].a, vecs[i].b);
            e8  = SAT ? vecs[i].s8  : vecs[i].w8;
            e16 = SAT ? vecs[i].s16 : vecs[i].w16;
            for (int l = 0; l < 4; l++) begin
                check($sformatf("table%0d_w8_lat%0d", i, l + 1), {8'd0, x8[l]}, e8);
                check($sformatf("table%0d_w16_lat%0d", i, l + 1), x16[l], e16);
            end
        end

        // Back-to-back 1+1, 2+2, 3+3: no bubbles at any latency.
        for (int c = 0; c < 7; c++) begin
            ra = (c < 3) ? 16'(c + 1) : 16'd0;
            step(1'b0, ra, ra);
            for (int l = 0; l < 4; l++) begin
                if (c >= l && c <= l + 2) begin
                    check($sformatf("b2b_w8_lat%0d", l + 1), {8'd0, x8[l]}, 2 * (c - l + 1));
                    check($sformatf("b2b_w16_lat%0d", l + 1), x16[l], 2 * (c - l + 1));
                end
            end
        end

        // Ramp with a one-cycle reset in the middle.
        ra = 16'd0;
        for (int c = 0; c < 600; c++) begin
            if (c == 333) begin
                step(1'b1, ra, ra);
                for (int l = 0; l < 4; l++) begin
                    check("midreset_w8", {8'd0, x8[l]}, 0);
                    check("midreset_w16", x16[l], 0);
                end
            end else begin
                step(1'b0, ra, ra);
            end
            ra = (ra + 16'd1) % 16'd200;
        end

        // Randomised operands with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            ra = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : 16'($urandom);
            rb = ($urandom_range(3) == 0) ? corner[$urandom_range(5)] : 16'($urandom);
            step($urandom_range(63) == 0, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
